core_wbarb: RTL and testbench
=============================

CORE_WBARB -- requirements
Module: core_wbarb

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width; byte selects are DW/8 bits wide.
REQ-003 Parameter TO_CYCLES, default 64, bus watchdog limit in cycles; only used when CORE_WBARB_TIMEOUT_EN is defined.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mN_cyc_i (N=0 fetch, N=1 mau)  input  1  master N requests and holds the bus.
REQ-007 mN_we_i  input  1  master N write enable.
REQ-008 mN_adr_i  input  AW  master N address.
REQ-009 mN_dat_i  input  DW  master N write data.
REQ-010 mN_sel_i  input  DW/8  master N byte selects.
REQ-011 mN_dat_o  output  DW  read data to master N.
REQ-012 mN_ack_o, mN_err_o, mN_try_o  output  1 each  termination signals to master N.
REQ-013 cyc_o, we_o  output  1 each  shared wishbone cycle and write enable.
REQ-014 adr_o, dat_o, sel_o  output  AW, DW, DW/8  shared wishbone address, write data and byte selects.
REQ-015 dat_i, ack_i, err_i, try_i  input  DW, 1, 1, 1  shared wishbone read data and terminations.
REQ-016 gnt_o  output  2  one-hot current grant: bit0 = m0, bit1 = m1; 00 when idle.

Function
REQ-017 FSM states: IDLE, GNT0, GNT1, ABORT; ABORT exists only with CORE_WBARB_TIMEOUT_EN.
REQ-018 IDLE, only m0 requesting -> GNT0; only m1 requesting -> GNT1.
REQ-019 IDLE, both requesting -> grant goes to the master not granted last (round-robin via a 1-bit last register).
REQ-020 Latency: a request sampled in IDLE at edge n produces cyc_o=1 in cycle n+1.
REQ-021 GNTx holds while mx_cyc_i=1; the master may run any number of back-to-back transfers.
REQ-022 GNTx -> IDLE on the edge where mx_cyc_i=0; last := x.
REQ-023 There is at least one idle cycle (cyc_o=0) between consecutive grants.
REQ-024 In GNTx, cyc_o = mx_cyc_i, and adr_o/dat_o/sel_o/we_o are combinationally muxed from master x.
REQ-025 In IDLE and ABORT, cyc_o = 0, we_o = 0 and sel_o = 0.
REQ-026 ack_i/err_i/try_i are routed only to the granted master; the non-granted master sees 0 on all three.
REQ-027 dat_i is broadcast to m0_dat_o and m1_dat_o unconditionally.
REQ-028 A request from the non-granted master never disturbs an in-progress grant.

Reset
REQ-029 rst=1 at an edge forces state IDLE and last=1 (so m0 wins the first tie) and clears the watchdog counter.
REQ-030 From the cycle after reset: cyc_o=0, gnt_o=00, all mN_ack_o/err_o/try_o = 0.
REQ-031 Reset mid-transfer abandons the cycle; the slave sees cyc_o drop on the next cycle.

Configuration
REQ-032 Macro CORE_WBARB_TIMEOUT_EN defined: a counter clears on entry to GNTx and on any ack_i/err_i/try_i, and increments in each other granted cycle with cyc_o=1.
REQ-033 With CORE_WBARB_TIMEOUT_EN, when the count reaches TO_CYCLES-1 with no response: mx_err_o pulses for 1 cycle and the FSM goes to ABORT.
REQ-034 With CORE_WBARB_TIMEOUT_EN, ABORT holds cyc_o=0 until mx_cyc_i=0, then -> IDLE with last := x.
REQ-035 Macro not defined: no counter and no ABORT state; a granted cycle waits indefinitely for a slave response.

Verification
REQ-036 Only m1 requests a read, slave acks 2 cycles after cyc_o -> cyc_o rises 1 cycle after the request, m1_ack_o=1, m1_dat_o=dat_i, m0_ack_o=0.
REQ-037 m0 and m1 both request in the same IDLE cycle after reset -> GNT0 first; m0 drops cyc -> 1 idle cycle -> GNT1.
REQ-038 m0 holds cyc for 4 acked writes while m1 requests -> gnt_o=01 throughout; GNT1 follows 1 idle cycle after m0 drops cyc.
REQ-039 rst asserted during GNT1 with cyc_o=1 -> next cycle cyc_o=0, gnt_o=00; a subsequent simultaneous request goes to m0.
REQ-040 TIMEOUT_EN, TO_CYCLES=8, slave never responds -> m0_err_o pulses once after 8 granted cycles, cyc_o=0 until m0 drops cyc; without the macro, cyc_o stays high indefinitely.

Source files
------------

// File: rtl/core_wbarb.sv
// Two-master wishbone arbiter (fetch = m0, mau = m1), round-robin on ties.
// Optional bus watchdog enabled by defining CORE_WBARB_TIMEOUT_EN.
module core_wbarb #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TO_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_cyc_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_try_o,
  input  logic            m1_cyc_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_try_o,
  output logic            cyc_o,
  output logic            we_o,
  output logic [AW-1:0]   adr_o,
  output logic [DW-1:0]   dat_o,
  output logic [DW/8-1:0] sel_o,
  input  logic [DW-1:0]   dat_i,
  input  logic            ack_i,
  input  logic            err_i,
  input  logic            try_i,
  output logic [1:0]      gnt_o
);

`ifdef CORE_WBARB_TIMEOUT_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;
`endif

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   g0, g1;
  logic   to_hit;

  assign g0    = (state_q == GNT0);
  assign g1    = (state_q == GNT1);
  assign gnt_o = {g1, g0};

`ifdef CORE_WBARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES) + 1;

  logic [CW-1:0] cnt_q;
  logic          own_q;
  logic          own_cyc;
  logic          resp;

  assign resp    = ack_i | err_i | try_i;
  assign own_cyc = own_q ? m1_cyc_i : m0_cyc_i;
  assign to_hit  = (g0 | g1) & cyc_o & ~resp &
                   (cnt_q == CW'(TO_CYCLES - 1));

  // Counter sits at zero outside a grant, so grant entry starts it clean.
  always_ff @(posedge clk) begin
    if (rst || !(g0 || g1) || resp)
      cnt_q <= '0;
    else if (cyc_o)
      cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      own_q <= 1'b0;
    else if (to_hit)
      own_q <= g1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q))
          state_d = GNT0;
        else if (m1_cyc_i)
          state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
`ifdef CORE_WBARB_TIMEOUT_EN
        else if (to_hit)
          state_d = ABORT;
`endif
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
`ifdef CORE_WBARB_TIMEOUT_EN
        else if (to_hit)
          state_d = ABORT;
`endif
      end
`ifdef CORE_WBARB_TIMEOUT_EN
      ABORT: begin
        if (!own_cyc) begin
          state_d = IDLE;
          last_d  = own_q;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cyc_o = 1'b0;
    we_o  = 1'b0;
    adr_o = '0;
    dat_o = '0;
    sel_o = '0;
    unique case (1'b1)
      g0: begin
        cyc_o = m0_cyc_i;
        we_o  = m0_we_i;
        adr_o = m0_adr_i;
        dat_o = m0_dat_i;
        sel_o = m0_sel_i;
      end
      g1: begin
        cyc_o = m1_cyc_i;
        we_o  = m1_we_i;
        adr_o = m1_adr_i;
        dat_o = m1_dat_i;
        sel_o = m1_sel_i;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = dat_i;
  assign m1_dat_o = dat_i;
  assign m0_ack_o = g0 & ack_i;
  assign m1_ack_o = g1 & ack_i;
  assign m0_try_o = g0 & try_i;
  assign m1_try_o = g1 & try_i;
  assign m0_err_o = g0 & (err_i | to_hit);
  assign m1_err_o = g1 & (err_i | to_hit);

endmodule

// File: tb/tb_core_wbarb.sv
// Directed bench for core_wbarb with read/write data scoreboards.
// Timeout path is exercised when CORE_WBARB_TIMEOUT_EN is defined.
module tb_core_wbarb;

  logic        clk;
  logic        rst;
  logic        m0_cyc, m0_we, m1_cyc, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m0_try_o;
  logic        m1_ack_o, m1_err_o, m1_try_o;
  logic        cyc_o, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack_i, err_i, try_i;
  logic [1:0]  gnt_o;

  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];
  int          n_tests;
  int          n_fail;
  logic [31:0] exp_rd;

  core_wbarb #(.AW(32), .DW(32), .TO_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_try_o(m0_try_o),
    .m1_cyc_i(m1_cyc), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_try_o(m1_try_o),
    .cyc_o(cyc_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i),
    .try_i(try_i), .gnt_o(gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return a ^ 32'hA5A5_3C3C;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    m0_cyc = 0; m0_we = 0; m0_adr = 0; m0_dat = 0; m0_sel = 0;
    m1_cyc = 0; m1_we = 0; m1_adr = 0; m1_dat = 0; m1_sel = 0;
    dat_i = 0; ack_i = 0; err_i = 0; try_i = 0;
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("rst_cyc", cyc_o, 0);
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_term", {m0_ack_o, m0_err_o, m0_try_o,
                     m1_ack_o, m1_err_o, m1_try_o}, 6'b0);

    // m1 alone reads, slave acks two cycles after cyc_o rises
    m1_cyc = 1; m1_we = 0; m1_adr = 32'h1000_0040; m1_sel = 4'hF;
    rd_q.push_back(rdata(m1_adr));
    exp_rd = rdata(m1_adr);
    #1;
    chk("lat_idle_cyc", cyc_o, 0);
    tick; #1;
    chk("m1_cyc", cyc_o, 1);
    chk("m1_gnt", gnt_o, 2'b10);
    chk("m1_adr", adr_o, 32'h1000_0040);
    chk("m1_we", we_o, 0);
    tick; #1;
    chk("m1_noack", m1_ack_o, 0);
    tick;
    ack_i = 1; dat_i = rdata(adr_o);
    #1;
    chk("m1_ack", m1_ack_o, 1);
    chk("m0_ack_mask", m0_ack_o, 0);
    chk("m1_rdat", m1_dat_o, rd_q.pop_front());
    chk("m0_bcast", m0_dat_o, exp_rd);
    tick;
    ack_i = 0; m1_cyc = 0;
    #1;
    chk("m1_drop_cyc", cyc_o, 0);
    tick; #1;
    chk("m1_idle_gnt", gnt_o, 2'b00);

    // tie after reset goes to m0, then m1 after an idle cycle
    rst = 1;
    tick;
    rst = 0;
    m0_cyc = 1; m0_we = 1; m0_adr = 32'h2000_0010;
    m0_dat = 32'hDEAD_BEEF; m0_sel = 4'hF;
    m1_cyc = 1; m1_we = 0; m1_adr = 32'h3000_0008; m1_sel = 4'h3;
    wr_q.push_back(m0_dat);
    rd_q.push_back(rdata(m1_adr));
    tick; #1;
    chk("tie_gnt0", gnt_o, 2'b01);
    chk("tie_adr", adr_o, 32'h2000_0010);
    chk("tie_we", we_o, 1);
    chk("tie_sel", sel_o, 4'hF);
    ack_i = 1;
    #1;
    chk("m0_ack", m0_ack_o, 1);
    chk("m1_ack_mask", m1_ack_o, 0);
    chk("m0_wdat", dat_o, wr_q.pop_front());
    tick;
    ack_i = 0; err_i = 1;
    #1;
    chk("m0_err", {m0_err_o, m1_err_o}, 2'b10);
    tick;
    err_i = 0; try_i = 1;
    #1;
    chk("m0_try", {m0_try_o, m1_try_o}, 2'b10);
    tick;
    try_i = 0; m0_cyc = 0;
    #1;
    chk("m0_drop_cyc", cyc_o, 0);
    tick; #1;
    chk("gap_gnt", gnt_o, 2'b00);
    chk("gap_cyc_we_sel", {cyc_o, we_o, sel_o}, 6'b0);
    tick; #1;
    chk("rr_gnt1", gnt_o, 2'b10);
    chk("rr_adr", adr_o, 32'h3000_0008);

    // m0 request must not disturb the m1 grant
    m0_cyc = 1; m0_we = 1;
    ack_i = 1; dat_i = rdata(adr_o);
    #1;
    chk("hold_gnt1", gnt_o, 2'b10);
    chk("m1_ack2", {m1_ack_o, m0_ack_o}, 2'b10);
    chk("m1_rdat2", m1_dat_o, rd_q.pop_front());
    tick;
    ack_i = 0; m1_cyc = 0;
    tick; #1;
    chk("idle2_gnt", gnt_o, 2'b00);
    m1_cyc = 1;
    tick; #1;
    chk("rr_back_m0", gnt_o, 2'b01);

    // four back-to-back acked writes from m0 while m1 waits
    for (int i = 0; i < 4; i++) begin
      m0_adr = 32'h0000_0200 + 32'(4 * i);
      m0_dat = $urandom;
      wr_q.push_back(m0_dat);
      ack_i = 1;
      #1;
      chk("burst_gnt", gnt_o, 2'b01);
      chk("burst_ack", {m0_ack_o, m1_ack_o}, 2'b10);
      chk("burst_adr", adr_o, 32'h0000_0200 + 32'(4 * i));
      chk("burst_wdat", dat_o, wr_q.pop_front());
      tick;
    end
    ack_i = 0; m0_cyc = 0;
    #1;
    chk("burst_end_gnt", gnt_o, 2'b01);
    tick; #1;
    chk("burst_gap", {gnt_o, cyc_o}, 3'b000);
    tick; #1;
    chk("burst_next_m1", gnt_o, 2'b10);
    chk("burst_next_cyc", cyc_o, 1);

    // reset mid-grant drops the cycle; next tie goes to m0
    m0_cyc = 1;
    rst = 1;
    tick;
    rst = 0;
    #1;
    chk("rstmid_cyc", cyc_o, 0);
    chk("rstmid_gnt", gnt_o, 2'b00);
    tick; #1;
    chk("rstmid_tie_m0", gnt_o, 2'b01);
    m0_cyc = 0; m1_cyc = 0;
    tick;
    tick;

    // unanswered cycle from m0
    m0_cyc = 1; m0_we = 0; m0_adr = 32'h4000_0000;
    tick; #1;
    chk("stall_gnt", gnt_o, 2'b01);
`ifdef CORE_WBARB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      chk("to_wait_err", m0_err_o, 0);
      chk("to_wait_cyc", cyc_o, 1);
      tick; #1;
    end
    chk("to_err", {m0_err_o, m1_err_o}, 2'b10);
    tick; #1;
    chk("abort_cyc", cyc_o, 0);
    chk("abort_err", m0_err_o, 0);
    chk("abort_gnt", gnt_o, 2'b00);
    tick;
    tick; #1;
    chk("abort_hold", cyc_o, 0);
    m0_cyc = 0;
    tick; #1;
    chk("abort_exit", gnt_o, 2'b00);
    m0_cyc = 1; m1_cyc = 1;
    tick; #1;
    chk("abort_rr_m1", gnt_o, 2'b10);
    m0_cyc = 0; m1_cyc = 0;
    tick;
`else
    repeat (20) tick;
    #1;
    chk("stall_cyc", cyc_o, 1);
    chk("stall_err", m0_err_o, 0);
    chk("stall_gnt2", gnt_o, 2'b01);
    m0_cyc = 0;
    tick;
`endif
    tick;
    chk("rdq_empty", rd_q.size(), 0);
    chk("wrq_empty", wr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
